// File: rtl/decoder_scan.sv
// N-to-2**N one-hot decoder with registered outputs, plus an auto-scan mode
// that steps the index with a programmable per-output dwell time.
module decoder_scan #(
    parameter int unsigned N       = 3,
    parameter int unsigned DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [N-1:0]         a,
    input  logic                 valid_in,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [(2**N)-1:0]    y,
    output logic [N-1:0]         idx,
    output logic                 valid_out,
    output logic                 wrap
);

    localparam int unsigned M       = 2 ** N;
    localparam logic [M-1:0] ONE    = M'(1);
    localparam logic [N-1:0] IDX_MAX = {N{1'b1}};

    logic [M-1:0]       y_q, y_d;
    logic [N-1:0]       idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    // Mode seen on the last enabled cycle; a 0 here marks the scan entry cycle.
    logic               scan_q, scan_d;

    // Next-state logic; everything holds unless en is high.
    always_comb begin
        y_d     = y_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        scan_d  = scan_q;
        if (en) begin
            scan_d = mode;
            if (!mode) begin
                cnt_d   = '0;
                valid_d = valid_in;
                if (valid_in) begin
                    idx_d = a;
                    y_d   = ONE << a;
                end
            end else begin
                valid_d = 1'b1;
                if (!scan_q) begin
                    cnt_d = '0;
                end else if (cnt_q >= dwell) begin
                    // >= rather than == so a lowered dwell advances immediately.
                    cnt_d  = '0;
                    idx_d  = idx_q + N'(1);
                    wrap_d = (idx_q == IDX_MAX);
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
                y_d = ONE << idx_d;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            scan_q  <= 1'b0;
        end else begin
            y_q     <= y_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            scan_q  <= scan_d;
        end
    end

    assign y         = y_q;
    assign idx       = idx_q;
    assign valid_out = valid_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan (N=3, DWELL_W=8) using an expected-value
// queue filled as stimulus is driven and drained one cycle later.
module tb_decoder_scan;

    localparam int unsigned N  = 3;
    localparam int unsigned DW = 8;
    localparam int unsigned M  = 8;

    logic          clk = 1'b0;
    logic          rst, en, mode, valid_in;
    logic [N-1:0]  a;
    logic [DW-1:0] dwell;
    logic [M-1:0]  y;
    logic [N-1:0]  idx;
    logic          valid_out, wrap;

    always #5 clk = ~clk;

    decoder_scan #(.N(N), .DWELL_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .a         (a),
        .valid_in  (valid_in),
        .dwell     (dwell),
        .y         (y),
        .idx       (idx),
        .valid_out (valid_out),
        .wrap      (wrap)
    );

    typedef struct packed {
        logic [7:0] y;
        logic [2:0] idx;
        logic       v;
        logic       w;
    } exp_t;

    exp_t        exp_q[$];
    string       tag_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    function automatic exp_t ex(input int unsigned i, input logic v, input logic w);
        exp_t       e;
        logic [7:0] one;
        one   = 8'd1;
        e.y   = one << i;
        e.idx = 3'(i);
        e.v   = v;
        e.w   = w;
        return e;
    endfunction

    function automatic exp_t ex0();
        exp_t e;
        e = '0;
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_pending();
        exp_t  e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            cmp({t, " y"},     y,               e.y);
            cmp({t, " idx"},   8'(idx),         8'(e.idx));
            cmp({t, " valid"}, 8'(valid_out),   8'(e.v));
            cmp({t, " wrap"},  8'(wrap),        8'(e.w));
        end
    endtask

    // Drive one cycle of stimulus and queue what the outputs must be after the next edge.
    task automatic step(input logic r, input logic e_v, input logic m, input logic vin,
                        input logic [2:0] av, input logic [7:0] dw, input exp_t e,
                        input string tag);
        @(negedge clk);
        check_pending();
        rst      = r;
        en       = e_v;
        mode     = m;
        valid_in = vin;
        a        = av;
        dwell    = dw;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; valid_in = 1'b0; a = '0; dwell = '0;

        // Reset for two cycles, then direct decode of every select value.
        step(1, 1, 0, 1, 3'd4, 8'd0, ex0(), "rst0");
        step(1, 1, 1, 1, 3'd4, 8'd0, ex0(), "rst1");
        step(0, 1, 0, 0, 3'd6, 8'd0, ex0(), "direct novalid after rst");
        for (int i = 0; i < 8; i++)
            step(0, 1, 0, 1, 3'(i), 8'd0, ex(i, 1, 0), $sformatf("direct a=%0d", i));

        // Single valid pulse then valid_in low: decode holds, valid drops.
        step(0, 1, 0, 1, 3'd5, 8'd0, ex(5, 1, 0), "direct a=5");
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 0, 3'(i), 8'd0, ex(5, 0, 0), $sformatf("hold5 %0d", i));
        step(0, 0, 0, 1, 3'd2, 8'd0, ex(5, 0, 0), "direct en=0 hold");
        step(1, 0, 1, 1, 3'd2, 8'd0, ex0(), "rst beats en=0");

        // Scan with dwell=2: each index for 3 cycles, wrap on the 7->0 step.
        for (int k = 0; k < 27; k++)
            step(0, 1, 1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'd2,
                 ex((k / 3) % 8, 1, k == 24), $sformatf("scan d2 k=%0d", k));

        // Scan with dwell=0 and a 4-cycle enable gap at idx=3.
        step(1, 1, 1, 0, 3'd0, 8'd0, ex0(), "rst d0");
        for (int k = 0; k < 4; k++)
            step(0, 1, 1, 0, 3'd0, 8'd0, ex(k, 1, 0), $sformatf("scan d0 k=%0d", k));
        for (int k = 0; k < 4; k++)
            step(0, 0, 1, 0, 3'd0, 8'd0, ex(3, 1, 0), $sformatf("en gap %0d", k));
        for (int k = 4; k < 10; k++)
            step(0, 1, 1, 0, 3'd0, 8'd0, ex(k % 8, 1, k == 8), $sformatf("resume k=%0d", k));

        // Dwell lowered from 10 to 3 while the count sits at 7.
        step(1, 1, 1, 0, 3'd0, 8'd10, ex0(), "rst d10");
        for (int k = 0; k < 8; k++)
            step(0, 1, 1, 0, 3'd0, 8'd10, ex(0, 1, 0), $sformatf("d10 k=%0d", k));
        for (int k = 0; k < 9; k++)
            step(0, 1, 1, 0, 3'd0, 8'd3, ex(1 + k / 4, 1, 0), $sformatf("d3 k=%0d", k));

        // Reset mid-scan at idx=6, then scan restarts from 0.
        step(1, 1, 1, 0, 3'd0, 8'd0, ex0(), "rst pre-mid");
        for (int k = 0; k < 7; k++)
            step(0, 1, 1, 0, 3'd0, 8'd0, ex(k, 1, 0), $sformatf("mid k=%0d", k));
        step(1, 1, 1, 0, 3'd0, 8'd0, ex0(), "rst mid-scan");
        for (int k = 0; k < 3; k++)
            step(0, 1, 1, 0, 3'd0, 8'd0, ex(k, 1, 0), $sformatf("restart k=%0d", k));

        // Scan -> direct -> scan: entry cycle keeps idx and presents 1<<idx.
        step(0, 1, 0, 1, 3'd3, 8'd0, ex(3, 1, 0), "to direct a=3");
        step(0, 0, 1, 1, 3'd7, 8'd0, ex(3, 1, 0), "en=0 in direct");
        step(0, 1, 1, 0, 3'd7, 8'd0, ex(3, 1, 0), "scan entry idx3");
        step(0, 1, 1, 0, 3'd7, 8'd0, ex(4, 1, 0), "scan after entry");
        step(0, 1, 0, 0, 3'd1, 8'd0, ex(4, 0, 0), "to direct novalid");

        @(negedge clk);
        check_pending();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
